instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
IF stage of the 5-stage MIPS pipeline. Holds the PC and the instruction memory, and drives the IF/ID latch: the fetched instruction plus PC+1 that instruction_decode consumes. It handles hazard stalls, branch/jump redirection with flush, HALT detection, and program loading before run.

Parameters:
NB_DATA, 32, instruction/data width
NB_PC, 10, PC width; log2(ROM_DEPTH)
ROM_DEPTH, 1024, instruction memory depth in words
NB_OPCODE, 6, opcode field width, bits [NB_DATA-1 -: NB_OPCODE]
HALT_OPCODE, 6'b111111, opcode that halts fetch

Ports:
i_clock  in  1  system clock, rising edge
i_reset_n  in  1  synchronous reset, active-low
i_start  in  1  start execution from PC 0; honoured only in IDLE
i_prog_wr_enb  in  1  program memory write strobe; honoured only in IDLE
i_prog_wr_addr  in  NB_PC  program write address
i_prog_wr_data  in  NB_DATA  program write data
i_stall  in  1  hazard unit: hold PC and IF/ID latch
i_branch_taken  in  1  redirect request (branch/jump resolved downstream)
i_branch_target  in  NB_PC  redirect target word address
o_pipeline_ifu_instruction  out  NB_DATA  IF/ID latched instruction
o_pc_stage_0  out  NB_PC  IF/ID latched PC+1
o_instruction_valid  out  1  IF/ID holds a real (non-bubble) instruction
o_pc  out  NB_PC  current fetch PC
o_halted  out  1  HALT state reached
o_running  out  1  RUN state

Behaviour:
- Instruction memory: ROM_DEPTH x NB_DATA. Synchronous write from the prog port. Combinational read at o_pc. Contents are not cleared by reset.
- FSM has three states: IDLE, RUN, HALT.
- Reset (i_reset_n=0 at a clock edge):
  - state=IDLE, pc=0
  - IF/ID instruction=0 (NOP), o_pc_stage_0=0
  - o_instruction_valid=0, o_halted=0, o_running=0
  - Reset wins over every other input, including mid-RUN.
- IDLE:
  - Prog writes are accepted each cycle.
  - IF/ID holds NOP, valid=0.
  - i_start=1: next state RUN, pc=0. The first fetch happens on the first RUN cycle.
  - If i_start and i_prog_wr_enb are both high, the write is performed and the FSM still moves to RUN.
- RUN, per-edge priority:
  1. i_branch_taken=1: pc<=i_branch_target; IF/ID<=NOP, valid<=0. This wins over i_stall and over a HALT fetch in the same cycle.
  2. i_stall=1: pc, IF/ID and valid all hold.
  3. Fetched opcode == HALT_OPCODE: IF/ID<=HALT word, o_pc_stage_0<=pc+1, valid<=1; pc holds; state<=HALT.
  4. Otherwise: IF/ID<=mem[pc], o_pc_stage_0<=pc+1, valid<=1, pc<=pc+1.
- Latency: an instruction at address A appears on o_pipeline_ifu_instruction one edge after o_pc==A with no stall.
- Width rules:
  - pc+1 is computed modulo 2^NB_PC, so ROM_DEPTH-1 wraps to 0.
  - i_branch_target is used as-is; it is already NB_PC bits.
- HALT:
  - Sticky until reset; i_start is ignored.
  - First cycle: IF/ID shows the HALT instruction with valid=1. From the next edge on it shows NOP with valid=0.
  - pc frozen, o_halted=1; stall, branch and prog inputs are ignored.
- Prog writes in RUN or HALT are dropped, and memory is unchanged.
- o_running=1 exactly while state==RUN.

Test Plan:
1. Sequential fetch: load mem[0..3]=0x20010005, 0x20020003, 0x00221820, 0xFC000000; pulse i_start -> IF/ID shows the words in order with o_pc_stage_0=1,2,3,4; after the HALT word, valid=0, o_halted=1, o_pc=3 frozen.
2. Stall: stall for 2 cycles while IF/ID=0x20020003 -> IF/ID and o_pc (=2) hold for both cycles; fetch resumes with 0x00221820 on the edge after stall drops.
3. Branch flush: with i_branch_taken=1, i_branch_target=0 and i_stall=1 in the same cycle at o_pc=2 -> next edge IF/ID=0, valid=0, o_pc=0; the following edge IF/ID=0x20010005.
4. Branch vs HALT: a HALT word is at mem[3] and a redirect to 0 occurs while o_pc=3 -> no HALT; state stays RUN and fetch restarts at 0.
5. Reset mid-run: drive i_reset_n=0 at o_pc=2 -> next edge state IDLE, all outputs 0, memory contents unchanged; a subsequent i_start refetches 0x20010005.
6. Write guard and wrap: prog write to addr 0 during RUN -> mem[0] unchanged. Run with NB_PC=10, mem[1023] non-HALT -> o_pc goes 1023 to 0 and o_pc_stage_0=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: MIPS IF stage with PC, program memory and IF/ID latch.
// Program is loaded in IDLE, fetched in RUN and fetch stops for good on a HALT opcode.
module instruction_fetch_unit #(
  parameter int NB_DATA = 32,
  parameter int NB_PC = 10,
  parameter int ROM_DEPTH = 1024,
  parameter int NB_OPCODE = 6,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE = 6'b111111
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic               i_prog_wr_enb,
  input  logic [NB_PC-1:0]   i_prog_wr_addr,
  input  logic [NB_DATA-1:0] i_prog_wr_data,
  input  logic               i_stall,
  input  logic               i_branch_taken,
  input  logic [NB_PC-1:0]   i_branch_target,
  output logic [NB_DATA-1:0] o_pipeline_ifu_instruction,
  output logic [NB_PC-1:0]   o_pc_stage_0,
  output logic               o_instruction_valid,
  output logic [NB_PC-1:0]   o_pc,
  output logic               o_halted,
  output logic               o_running
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2;
  logic [NB_DATA-1:0] mem [ROM_DEPTH];
  logic [1:0] state_q, state_d;
  logic [NB_PC-1:0] pc_q, pc_d, pc1_q, pc1_d, pc_inc;
  logic [NB_DATA-1:0] ir_q, ir_d, fetched;
  logic valid_q, valid_d, is_halt;
  assign fetched = mem[pc_q];
  assign pc_inc = pc_q + NB_PC'(1);
  assign is_halt = fetched[NB_DATA-1 -: NB_OPCODE] == HALT_OPCODE;
  // memory has no reset so a loaded program survives a reset
  always_ff @(posedge i_clock)
    if (i_reset_n && state_q == IDLE && i_prog_wr_enb) mem[i_prog_wr_addr] <= i_prog_wr_data;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    pc1_d = pc1_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        ir_d = '0;
        valid_d = 1'b0;
        state_d = i_start ? RUN : IDLE;
        pc_d = i_start ? '0 : pc_q;
      end
      RUN:
        if (i_branch_taken) begin
          pc_d = i_branch_target;
          ir_d = '0;
          valid_d = 1'b0;
        end else if (!i_stall) begin
          ir_d = fetched;
          pc1_d = pc_inc;
          valid_d = 1'b1;
          state_d = is_halt ? HALT : RUN;
          pc_d = is_halt ? pc_q : pc_inc;
        end
      HALT: begin
        ir_d = '0;
        valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clock)
    if (!i_reset_n) begin
      state_q <= IDLE;
      pc_q <= '0;
      ir_q <= '0;
      pc1_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      pc1_q <= pc1_d;
      valid_q <= valid_d;
    end
  assign o_pipeline_ifu_instruction = ir_q;
  assign o_pc_stage_0 = pc1_q;
  assign o_instruction_valid = valid_q;
  assign o_pc = pc_q;
  assign o_halted = state_q == HALT;
  assign o_running = state_q == RUN;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scenario tasks with a scoreboard of expected IF/ID words.
module tb_instruction_fetch_unit;
  logic clk = 0, rst_n = 0, start = 0, wr_enb = 0, stall = 0, branch = 0;
  logic [9:0] wr_addr = 0, target = 0;
  logic [31:0] wr_data = 0;
  logic [31:0] instr;
  logic [9:0] pc1, pc;
  logic valid, halted, running;
  int passed = 0, total = 0;
  typedef struct {logic [31:0] instr; logic [9:0] pc1;} exp_t;
  exp_t sb[$];
  exp_t e;
  localparam logic [31:0] W0 = 32'h20010005, W1 = 32'h20020003, W2 = 32'h00221820, W3 = 32'hFC000000;

  instruction_fetch_unit dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_prog_wr_enb(wr_enb),
    .i_prog_wr_addr(wr_addr), .i_prog_wr_data(wr_data), .i_stall(stall),
    .i_branch_taken(branch), .i_branch_target(target),
    .o_pipeline_ifu_instruction(instr), .o_pc_stage_0(pc1), .o_instruction_valid(valid),
    .o_pc(pc), .o_halted(halted), .o_running(running)
  );

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task prog(input logic [9:0] a, input logic [31:0] d);
    wr_enb = 1; wr_addr = a; wr_data = d;
    tick;
    wr_enb = 0;
  endtask

  task do_reset;
    rst_n = 0;
    tick;
    rst_n = 1;
  endtask

  task do_start;
    start = 1;
    tick;
    start = 0;
  endtask

  task test_reset;
    start = 1;
    do_reset;
    start = 0;
    total++;
    if ({instr, pc1, valid, pc, halted, running} !== '0)
      $display("FAIL reset: instr=%h pc1=%0d valid=%b pc=%0d halted=%b running=%b, want all 0", instr, pc1, valid, pc, halted, running);
    else passed++;
  endtask

  task test_sequential_fetch;
    prog(0, W0); prog(1, W1); prog(2, W2); prog(3, W3);
    sb.push_back('{W0, 10'd1}); sb.push_back('{W1, 10'd2});
    sb.push_back('{W2, 10'd3}); sb.push_back('{W3, 10'd4});
    do_start;
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      tick;
      if (valid) begin
        e = sb.pop_front();
        total++;
        if (instr !== e.instr || pc1 !== e.pc1)
          $display("FAIL seq_fetch: instr=%h pc1=%0d, want %h pc1=%0d", instr, pc1, e.instr, e.pc1);
        else passed++;
      end
    end
    total++;
    if (sb.size() != 0) begin
      $display("FAIL seq_timeout: %0d words never fetched, want 0", sb.size());
      sb.delete();
    end else passed++;
    tick;
    total++;
    if (valid !== 0 || halted !== 1 || running !== 0 || pc !== 3)
      $display("FAIL halt_state: valid=%b halted=%b running=%b pc=%0d, want 0 1 0 3", valid, halted, running, pc);
    else passed++;
    start = 1; stall = 1; branch = 1; target = 7;
    tick; tick;
    start = 0; stall = 0; branch = 0; target = 0;
    total++;
    if (halted !== 1 || pc !== 3 || valid !== 0)
      $display("FAIL halt_sticky: halted=%b pc=%0d valid=%b, want 1 3 0", halted, pc, valid);
    else passed++;
  endtask

  task test_stall;
    do_reset;
    do_start;
    tick; tick;
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick;
      total++;
      if (instr !== W1 || pc !== 2 || valid !== 1)
        $display("FAIL stall_hold: instr=%h pc=%0d valid=%b, want %h 2 1", instr, pc, valid, W1);
      else passed++;
    end
    stall = 0;
    tick;
    total++;
    if (instr !== W2 || pc !== 3)
      $display("FAIL stall_resume: instr=%h pc=%0d, want %h 3", instr, pc, W2);
    else passed++;
  endtask

  task test_branch_flush;
    do_reset;
    do_start;
    tick; tick;
    branch = 1; target = 0; stall = 1;
    tick;
    branch = 0; stall = 0;
    total++;
    if (instr !== 0 || valid !== 0 || pc !== 0)
      $display("FAIL branch_flush: instr=%h valid=%b pc=%0d, want 0 0 0", instr, valid, pc);
    else passed++;
    tick;
    total++;
    if (instr !== W0 || pc1 !== 1 || valid !== 1)
      $display("FAIL branch_refetch: instr=%h pc1=%0d valid=%b, want %h 1 1", instr, pc1, valid, W0);
    else passed++;
  endtask

  task test_branch_vs_halt;
    do_reset;
    do_start;
    tick; tick; tick;
    branch = 1; target = 0;
    tick;
    branch = 0;
    total++;
    if (running !== 1 || halted !== 0 || pc !== 0 || valid !== 0)
      $display("FAIL branch_vs_halt: running=%b halted=%b pc=%0d valid=%b, want 1 0 0 0", running, halted, pc, valid);
    else passed++;
    tick;
    total++;
    if (instr !== W0 || running !== 1)
      $display("FAIL branch_vs_halt_fetch: instr=%h running=%b, want %h 1", instr, running, W0);
    else passed++;
  endtask

  task test_reset_mid_run;
    do_reset;
    do_start;
    tick; tick;
    rst_n = 0; start = 1; branch = 1; target = 5;
    tick;
    rst_n = 1; start = 0; branch = 0; target = 0;
    total++;
    if ({instr, pc1, valid, pc, halted, running} !== '0)
      $display("FAIL reset_mid_run: instr=%h pc1=%0d valid=%b pc=%0d halted=%b running=%b, want all 0", instr, pc1, valid, pc, halted, running);
    else passed++;
    do_start;
    tick;
    total++;
    if (instr !== W0 || pc1 !== 1)
      $display("FAIL reset_refetch: instr=%h pc1=%0d, want %h 1", instr, pc1, W0);
    else passed++;
  endtask

  task test_write_guard_wrap;
    prog(0, 32'hDEADBEEF);
    branch = 1; target = 0;
    tick;
    branch = 0;
    tick;
    total++;
    if (instr !== W0)
      $display("FAIL write_guard: instr=%h, want %h", instr, W0);
    else passed++;
    do_reset;
    prog(10'd1023, 32'h12345678);
    do_start;
    branch = 1; target = 10'd1023;
    tick;
    branch = 0;
    total++;
    if (pc !== 10'd1023)
      $display("FAIL wrap_target: pc=%0d, want 1023", pc);
    else passed++;
    sb.push_back('{32'h12345678, 10'd0});
    tick;
    e = sb.pop_front();
    total++;
    if (instr !== e.instr || pc1 !== e.pc1 || valid !== 1 || pc !== 0)
      $display("FAIL wrap: instr=%h pc1=%0d valid=%b pc=%0d, want %h %0d 1 0", instr, pc1, valid, pc, e.instr, e.pc1);
    else passed++;
  endtask

  initial begin
    tick;
    test_reset;
    test_sequential_fetch;
    test_stall;
    test_branch_flush;
    test_branch_vs_halt;
    test_reset_mid_run;
    test_write_guard_wrap;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
